sched_event_arbiter: RTL and testbench
======================================

# sched_event_arbiter

Arbitrates spike events from three requesters (external AER input, internal neuron spikes, time-reference ticks) into the single push port of the spike scheduler FIFO. Each accepted event is registered once and pushed only while the FIFO is not full, so no event is dropped under backpressure. It sits between the AER/neuron-core front end and the scheduler, and drives the scheduler's event strobe, virtual-event field and address.

## Interface
Parameters:
- M, 10, event address width; matches the scheduler address width.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- TREF_VALID  in  1  time-reference tick request.
- TREF_READY  out  1  tick accepted this cycle.
- EXT_VALID  in  1  external AER event request.
- EXT_VIRTS  in  2  external event virtual-type field.
- EXT_ADDR  in  M  external event address.
- EXT_READY  out  1  external event accepted this cycle.
- INT_VALID  in  1  internal neuron spike request.
- INT_ADDR  in  M  internal spiking neuron address.
- INT_READY  out  1  internal event accepted this cycle.
- SCHED_FULL  in  1  scheduler FIFO full.
- SCHED_EVENT_IN  out  1  push strobe to scheduler.
- SCHED_VIRTS  out  2  virtual-type field to scheduler.
- SCHED_ADDR  out  M  address to scheduler.
- EVT_CNT  out  CNT_W  saturating count of events pushed.
- BUSY  out  1  output register holds an un-pushed event.

## Operation
- One output register: out_valid, out_virts[1:0], out_addr[M-1:0].
- push = out_valid & ~SCHED_FULL; SCHED_EVENT_IN = push (combinational).
- load = ~out_valid | push. A requester is accepted only when load = 1 and it holds the grant.
- Grant: TREF has strict highest priority. When TREF_VALID = 0, EXT and INT are arbitrated per the Configuration section.
- READY_x = load & grant_x; READY is 1 for at most one requester per cycle and is never asserted when that requester's VALID = 0.
- Loaded payload:
  - TREF: virts = 2'b11, addr = 0.
  - EXT: EXT_VIRTS, EXT_ADDR.
  - INT: virts = 2'b00, INT_ADDR.
- On load with any grant, out_valid <= 1. On push without a new grant, out_valid <= 0.
- rr_last (1 bit, 0 = EXT last, 1 = INT last) updates only on an EXT or INT acceptance.
- EVT_CNT increments on every push and saturates at 2^CNT_W-1; it never wraps.
- BUSY = out_valid.
- Requesters must hold VALID and payload stable until READY. The block neither checks nor depends on payload changes before READY.

## Timing
- Reset values: out_valid = 0, SCHED_EVENT_IN = 0, SCHED_VIRTS = 0, SCHED_ADDR = 0, all READY = 0, EVT_CNT = 0, BUSY = 0, rr_last = 1 (EXT wins the first tie).
- Latency: accepted at edge N, SCHED_EVENT_IN high during cycle N+1 if SCHED_FULL = 0.
- Throughput: one event per cycle while SCHED_FULL = 0.
- SCHED_FULL = 1 with out_valid = 1:
  - Register holds; all READY = 0.
  - Push occurs in the first cycle SCHED_FULL drops.
  - A new event may be loaded in that same cycle.
- Simultaneous push and load: the old event is pushed and the new event is registered at the same edge; no bubble.
- Reset asserted mid-operation: the registered event is discarded; outputs reach reset values asynchronously.

## Configuration
- SCHED_ARB_RR_EN defined: EXT and INT are round-robin. When both are valid, grant goes to the one not equal to rr_last.
- SCHED_ARB_RR_EN undefined: fixed priority INT > EXT. rr_last logic is removed, and EXT may starve under continuous INT traffic.

## Test plan
- Reset: hold RSTN = 0, drive all VALID = 1 -> all outputs 0, EVT_CNT = 0. Release reset -> first acceptance is TREF.
- Single EXT event, EXT_VIRTS = 2'b01, EXT_ADDR = 0x155 -> EXT_READY for 1 cycle; next cycle SCHED_EVENT_IN = 1, VIRTS = 01, ADDR = 0x155; EVT_CNT = 1.
- Backpressure: SCHED_FULL = 1 for 5 cycles with event 0x0AA registered -> no push and READY = 0 throughout. On the FULL drop, a single push of 0x0AA occurs and the next event loads in the same cycle.
- All three VALID held for 5 acceptances, RR_EN defined -> order TREF, then EXT, INT, EXT, INT once TREF drops. RR_EN undefined -> INT every time.
- Continuous traffic, SCHED_FULL = 0 -> one push per cycle, no bubble, EVT_CNT = number of pushes.
- CNT_W = 4, 20 pushes -> EVT_CNT stops at 15.

Source files
------------

// File: rtl/sched_event_arbiter.sv
// Three-way event arbiter (TREF > EXT/INT) feeding the scheduler FIFO push port through one output register.
// Define SCHED_ARB_RR_EN for EXT/INT round-robin; otherwise INT has fixed priority over EXT.
module sched_event_arbiter #(
  parameter int unsigned M     = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             TREF_VALID,
  output logic             TREF_READY,
  input  logic             EXT_VALID,
  input  logic [1:0]       EXT_VIRTS,
  input  logic [M-1:0]     EXT_ADDR,
  output logic             EXT_READY,
  input  logic             INT_VALID,
  input  logic [M-1:0]     INT_ADDR,
  output logic             INT_READY,
  input  logic             SCHED_FULL,
  output logic             SCHED_EVENT_IN,
  output logic [1:0]       SCHED_VIRTS,
  output logic [M-1:0]     SCHED_ADDR,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             BUSY
);

  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_virts_q, out_virts_d;
  logic [M-1:0]     out_addr_q,  out_addr_d;
  logic [CNT_W-1:0] evt_cnt_q,   evt_cnt_d;

  logic push, load, accept;
  logic grant_tref, grant_ext, grant_int;

  assign push   = out_valid_q & ~SCHED_FULL;
  assign load   = ~out_valid_q | push;
  // RSTN gates acceptance so nothing is handshaken while reset is held
  assign accept = RSTN & load;

`ifdef SCHED_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant_tref = TREF_VALID;
    grant_ext  = ~TREF_VALID & EXT_VALID & (~INT_VALID |  rr_last_q);
    grant_int  = ~TREF_VALID & INT_VALID & (~EXT_VALID | ~rr_last_q);
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (EXT_READY)      rr_last_d = 1'b0;
    else if (INT_READY) rr_last_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end
`else
  always_comb begin
    grant_tref = TREF_VALID;
    grant_int  = ~TREF_VALID & INT_VALID;
    grant_ext  = ~TREF_VALID & EXT_VALID & ~INT_VALID;
  end
`endif

  assign TREF_READY = accept & grant_tref;
  assign EXT_READY  = accept & grant_ext;
  assign INT_READY  = accept & grant_int;

  always_comb begin
    out_valid_d = out_valid_q & ~push;
    out_virts_d = out_virts_q;
    out_addr_d  = out_addr_q;
    if (TREF_READY) begin
      out_valid_d = 1'b1;
      out_virts_d = 2'b11;
      out_addr_d  = '0;
    end else if (EXT_READY) begin
      out_valid_d = 1'b1;
      out_virts_d = EXT_VIRTS;
      out_addr_d  = EXT_ADDR;
    end else if (INT_READY) begin
      out_valid_d = 1'b1;
      out_virts_d = 2'b00;
      out_addr_d  = INT_ADDR;
    end
  end

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (push && (evt_cnt_q != '1)) evt_cnt_d = evt_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_valid_q <= 1'b0;
      out_virts_q <= '0;
      out_addr_q  <= '0;
      evt_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_virts_q <= out_virts_d;
      out_addr_q  <= out_addr_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  assign SCHED_EVENT_IN = push;
  assign SCHED_VIRTS    = out_virts_q;
  assign SCHED_ADDR     = out_addr_q;
  assign EVT_CNT        = evt_cnt_q;
  assign BUSY           = out_valid_q;

endmodule

// File: tb/tb_sched_event_arbiter.sv
// Scoreboard bench for sched_event_arbiter; a CNT_W=4 twin shares all inputs to check counter saturation.
module tb_sched_event_arbiter;

  localparam int M = 10;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          TREF_VALID, EXT_VALID, INT_VALID, SCHED_FULL;
  logic [1:0]    EXT_VIRTS;
  logic [M-1:0]  EXT_ADDR, INT_ADDR;
  logic          TREF_READY, EXT_READY, INT_READY;
  logic          SCHED_EVENT_IN, BUSY;
  logic [1:0]    SCHED_VIRTS;
  logic [M-1:0]  SCHED_ADDR;
  logic [15:0]   EVT_CNT;

  logic          t4_tref_rdy, t4_ext_rdy, t4_int_rdy, t4_push, t4_busy;
  logic [1:0]    t4_virts;
  logic [M-1:0]  t4_addr;
  logic [3:0]    t4_cnt;

  typedef struct packed {
    logic [1:0]   v;
    logic [M-1:0] a;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 CLK = ~CLK;

  sched_event_arbiter #(.M(M), .CNT_W(16)) u_dut (
    .CLK(CLK), .RSTN(RSTN),
    .TREF_VALID(TREF_VALID), .TREF_READY(TREF_READY),
    .EXT_VALID(EXT_VALID), .EXT_VIRTS(EXT_VIRTS), .EXT_ADDR(EXT_ADDR), .EXT_READY(EXT_READY),
    .INT_VALID(INT_VALID), .INT_ADDR(INT_ADDR), .INT_READY(INT_READY),
    .SCHED_FULL(SCHED_FULL), .SCHED_EVENT_IN(SCHED_EVENT_IN),
    .SCHED_VIRTS(SCHED_VIRTS), .SCHED_ADDR(SCHED_ADDR),
    .EVT_CNT(EVT_CNT), .BUSY(BUSY)
  );

  sched_event_arbiter #(.M(M), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RSTN(RSTN),
    .TREF_VALID(TREF_VALID), .TREF_READY(t4_tref_rdy),
    .EXT_VALID(EXT_VALID), .EXT_VIRTS(EXT_VIRTS), .EXT_ADDR(EXT_ADDR), .EXT_READY(t4_ext_rdy),
    .INT_VALID(INT_VALID), .INT_ADDR(INT_ADDR), .INT_READY(t4_int_rdy),
    .SCHED_FULL(SCHED_FULL), .SCHED_EVENT_IN(t4_push),
    .SCHED_VIRTS(t4_virts), .SCHED_ADDR(t4_addr),
    .EVT_CNT(t4_cnt), .BUSY(t4_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every push, checks handshake sanity on both instances.
  always @(negedge CLK) begin
    if (RSTN === 1'b1) begin
      if (SCHED_EVENT_IN === 1'b1) begin
        if (q.size() == 0) chk("unexpected_push", 32'(SCHED_ADDR), 32'hFFFF_FFFF);
        else begin
          ev_t e;
          e = q.pop_front();
          chk("push_virts", 32'(SCHED_VIRTS), 32'(e.v));
          chk("push_addr",  32'(SCHED_ADDR),  32'(e.a));
          chk("t4_push",    32'(t4_push),     32'd1);
          chk("t4_addr",    32'(t4_addr),     32'(e.a));
        end
      end
      chk("ready_onehot", 32'($countones({TREF_READY, EXT_READY, INT_READY}) <= 1), 32'd1);
      chk("ready_valid",  32'((TREF_READY & ~TREF_VALID) | (EXT_READY & ~EXT_VALID) |
                              (INT_READY & ~INT_VALID)), 32'd0);
    end
  end

  // who: 0 = TREF, 1 = EXT, 2 = INT. Called just after a posedge.
  task automatic send(input int who, input logic [1:0] v, input logic [M-1:0] a);
    bit seen;
    seen = 1'b0;
    case (who)
      0: begin TREF_VALID = 1'b1; q.push_back({2'b11, {M{1'b0}}}); end
      1: begin EXT_VALID = 1'b1; EXT_VIRTS = v; EXT_ADDR = a; q.push_back({v, a}); end
      default: begin INT_VALID = 1'b1; INT_ADDR = a; q.push_back({2'b00, a}); end
    endcase
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK);
      if ((who == 0 && TREF_READY) || (who == 1 && EXT_READY) || (who == 2 && INT_READY)) begin
        seen = 1'b1;
        break;
      end
    end
    chk("handshake", 32'(seen), 32'd1);
    @(posedge CLK); #1;
    TREF_VALID = 1'b0; EXT_VALID = 1'b0; INT_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_who [5];
    logic [2:0] who;
    bit         found;

`ifdef SCHED_ARB_RR_EN
    exp_who = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b001};
`else
    exp_who = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
`endif

    RSTN = 1'b0; SCHED_FULL = 1'b0;
    TREF_VALID = 1'b1; EXT_VALID = 1'b1; INT_VALID = 1'b1;
    EXT_VIRTS = 2'b01; EXT_ADDR = 10'h155; INT_ADDR = 10'h2AA;

    repeat (3) @(negedge CLK);
    chk("rst_tref_ready", 32'(TREF_READY), 32'd0);
    chk("rst_ext_ready",  32'(EXT_READY),  32'd0);
    chk("rst_int_ready",  32'(INT_READY),  32'd0);
    chk("rst_event_in",   32'(SCHED_EVENT_IN), 32'd0);
    chk("rst_virts",      32'(SCHED_VIRTS), 32'd0);
    chk("rst_addr",       32'(SCHED_ADDR),  32'd0);
    chk("rst_cnt",        32'(EVT_CNT),     32'd0);
    chk("rst_busy",       32'(BUSY),        32'd0);

    // Arbitration with all requesters held
    q.push_back({2'b11, 10'h000});
    for (int k = 1; k < 5; k++)
      q.push_back(exp_who[k] == 3'b010 ? {2'b01, 10'h155} : {2'b00, 10'h2AA});
    @(posedge CLK); #1;
    RSTN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      who   = 3'b000;
      for (int t = 0; t < 20; t++) begin
        @(negedge CLK);
        if (TREF_READY | EXT_READY | INT_READY) begin
          found = 1'b1;
          who   = {TREF_READY, EXT_READY, INT_READY};
          break;
        end
      end
      chk("arb_found", 32'(found), 32'd1);
      chk("arb_order", 32'(who), 32'(exp_who[k]));
      @(posedge CLK); #1;
      if (k == 0) TREF_VALID = 1'b0;
      if (k == 4) begin EXT_VALID = 1'b0; INT_VALID = 1'b0; end
    end
    repeat (3) @(negedge CLK);
    chk("arb_cnt", 32'(EVT_CNT), 32'd5);

    // Reset in the middle of a held event discards it
    @(posedge CLK); #1;
    SCHED_FULL = 1'b1;
    send(2, 2'b00, 10'h077);
    @(negedge CLK);
    chk("held_busy", 32'(BUSY), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("midrst_busy",  32'(BUSY),    32'd0);
    chk("midrst_cnt",   32'(EVT_CNT), 32'd0);
    chk("midrst_addr",  32'(SCHED_ADDR), 32'd0);
    chk("midrst_virts", 32'(SCHED_VIRTS), 32'd0);
    q.delete();
    @(posedge CLK); #1;
    SCHED_FULL = 1'b0; RSTN = 1'b1;

    // Single EXT event and its one-cycle latency
    @(posedge CLK); #1;
    send(1, 2'b01, 10'h155);
    @(negedge CLK);
    chk("ext_latency", 32'(SCHED_EVENT_IN), 32'd1);
    @(posedge CLK); #1;
    chk("ext_cnt", 32'(EVT_CNT), 32'd1);

    // Backpressure: hold 0x0AA for 5 full cycles, INT waits
    send(1, 2'b10, 10'h0AA);
    SCHED_FULL = 1'b1;
    INT_ADDR = 10'h0C3; INT_VALID = 1'b1;
    q.push_back({2'b00, 10'h0C3});
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("bp_no_push",  32'(SCHED_EVENT_IN), 32'd0);
      chk("bp_int_rdy",  32'(INT_READY), 32'd0);
      chk("bp_busy",     32'(BUSY), 32'd1);
    end
    @(posedge CLK); #1;
    SCHED_FULL = 1'b0;
    @(negedge CLK);
    chk("bp_release_push", 32'(SCHED_EVENT_IN), 32'd1);
    chk("bp_release_load", 32'(INT_READY), 32'd1);
    @(posedge CLK); #1;
    INT_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("bp_cnt", 32'(EVT_CNT), 32'd3);

    // Continuous INT traffic, one event per cycle
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      INT_VALID = 1'b1; INT_ADDR = 10'(10'h100 + i);
      q.push_back({2'b00, 10'(10'h100 + i)});
      @(negedge CLK);
      chk("stream_ready", 32'(INT_READY), 32'd1);
      if (i > 0) chk("stream_push", 32'(SCHED_EVENT_IN), 32'd1);
    end
    @(posedge CLK); #1;
    INT_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stream_cnt",    32'(EVT_CNT), 32'd15);
    chk("stream_cnt_w4", 32'(t4_cnt),  32'd15);

    // Five more pushes: the 4-bit counter must stay at 15
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      INT_VALID = 1'b1; INT_ADDR = 10'(10'h200 + i);
      q.push_back({2'b00, 10'(10'h200 + i)});
    end
    @(posedge CLK); #1;
    INT_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sat_cnt",    32'(EVT_CNT), 32'd20);
    chk("sat_cnt_w4", 32'(t4_cnt),  32'd15);
    chk("sat_idle",   32'(BUSY),    32'd0);
    chk("sb_empty",   32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
